// File: rtl/psum_decode_acc.sv
// rtl/psum_decode_acc.sv - decode compressed psum codes and accumulate ACC_LEN of them per result
module psum_decode_acc #(
    parameter int ACC_LEN = 3,
    parameter int ACC_W   = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_code,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_err
);

    typedef enum logic {S_ACC, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             part_sat;
    logic             part_err;

    logic [13:0]      dec_val;
    logic             dec_err;
    logic [ACC_W:0]   sum_full;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sat;
    logic             accept;
    logic             last_term;

    // Piecewise code decode to the 14-bit mid-bin value; illegal codes map to full scale
    always_comb begin
        dec_val = '0;
        dec_err = 1'b0;
        if (in_code < 8'd64) begin
            dec_val = {6'd0, in_code};
        end else if (in_code < 8'd190) begin
            dec_val = (({6'd0, in_code} - 14'd62) << 5) + 14'd16;
        end else if (in_code < 8'd222) begin
            dec_val = (({6'd0, in_code} - 14'd158) << 7) + 14'd64;
        end else begin
            dec_val = 14'h3FFF;
            dec_err = 1'b1;
        end
    end

    // Saturating add of the decoded term onto the running sum
    always_comb begin
        sum_full = {1'b0, acc} + {{(ACC_W + 1 - 14){1'b0}}, dec_val};
        sum_ovf  = sum_full[ACC_W];
        sum_sat  = sum_ovf ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
    end

    // Handshake decode; a waiting result only frees the input when it is being retired
    always_comb begin
        in_ready  = !rst && en && !clear && (state == S_ACC || out_ready);
        accept    = in_valid && in_ready;
        last_term = (cnt == 8'(ACC_LEN - 1));
        out_valid = (state == S_DONE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: finish a sum into DONE, leave DONE on retire unless a new result completes
    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                S_ACC: begin
                    if (accept && last_term) begin
                        state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_nxt = (accept && last_term) ? S_DONE : S_ACC;
                    end
                end
                default: state_nxt = S_ACC;
            endcase
        end
    end

    // Accumulator, term counter, partial flags and the held result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            part_sat <= 1'b0;
            part_err <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
            out_err  <= 1'b0;
        end else if (en) begin
            if (clear) begin
                acc      <= '0;
                cnt      <= '0;
                part_sat <= 1'b0;
                part_err <= 1'b0;
            end else if (accept) begin
                if (last_term) begin
                    out_data <= sum_sat;
                    out_sat  <= part_sat | sum_ovf;
                    out_err  <= part_err | dec_err;
                    acc      <= '0;
                    cnt      <= '0;
                    part_sat <= 1'b0;
                    part_err <= 1'b0;
                end else begin
                    acc      <= sum_sat;
                    cnt      <= cnt + 8'd1;
                    part_sat <= part_sat | sum_ovf;
                    part_err <= part_err | dec_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_psum_decode_acc.sv
// tb/tb_psum_decode_acc.sv - directed self-checking bench for psum_decode_acc
module tb_psum_decode_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_code;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [19:0] out_data;
    logic        out_sat;
    logic        out_err;

    logic        in_ready14;
    logic        out_valid14;
    logic [13:0] out_data14;
    logic        out_sat14;
    logic        out_err14;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psum_decode_acc dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_err(out_err)
    );

    psum_decode_acc #(.ACC_LEN(3), .ACC_W(14)) dut14 (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
        .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready14),
        .out_valid(out_valid14), .out_ready(out_ready),
        .out_data(out_data14), .out_sat(out_sat14), .out_err(out_err14)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        in_valid = 1'b1; in_code = a; step();
        in_valid = 1'b1; in_code = b; step();
        in_valid = 1'b1; in_code = c; step();
        in_valid = 1'b0; in_code = 8'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clear = 1'b0; in_valid = 1'b0; in_code = 8'd0; out_ready = 1'b1;
        step(); step();
        checks++;
        if ({out_valid, out_data, out_sat, out_err, in_ready} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b d=%0d s=%0b e=%0b rdy=%0b, expected all 0",
                     out_valid, out_data, out_sat, out_err, in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        send3(8'd10, 8'd20, 8'd63);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 20'd93 || out_sat !== 1'b0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got v=%0b d=%0d s=%0b e=%0b expected v=1 d=93 s=0 e=0",
                     out_valid, out_data, out_sat, out_err);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle: out_valid got %0b expected 0", out_valid);
        end
    endtask

    task automatic test_decode();
        send3(8'd64, 8'd189, 8'd190);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 20'd8320 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL decode_bins: got v=%0b d=%0d e=%0b expected v=1 d=8320 e=0",
                     out_valid, out_data, out_err);
        end
        step();
    endtask

    task automatic test_illegal();
        send3(8'd230, 8'd0, 8'd0);
        checks++;
        if (out_data !== 20'd16383 || out_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_code: got d=%0d e=%0b expected d=16383 e=1", out_data, out_err);
        end
        step();
        send3(8'd1, 8'd1, 8'd1);
        checks++;
        if (out_data !== 20'd3 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got d=%0d e=%0b expected d=3 e=0", out_data, out_err);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send3(8'd100, 8'd0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_code = 8'd7;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 20'd1232 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got v=%0b d=%0d rdy=%0b expected v=1 d=1232 rdy=0",
                         i, out_valid, out_data, in_ready);
            end
            step();
        end
        out_ready = 1'b1; in_valid = 1'b1; in_code = 8'd5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL retire_accept_ready: got %0b expected 1", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL retire_out_valid: got %0b expected 0", out_valid);
        end
        in_valid = 1'b1; in_code = 8'd6; step();
        in_valid = 1'b1; in_code = 8'd7; step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 20'd18) begin
            errors++;
            $display("FAIL no_bubble_result: got v=%0b d=%0d expected v=1 d=18", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_rst_mid();
        in_valid = 1'b1; in_code = 8'd10; step();
        in_valid = 1'b1; in_code = 8'd20; step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, out_sat, out_err, in_ready} !== 24'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v=%0b d=%0d s=%0b e=%0b rdy=%0b expected all 0",
                     out_valid, out_data, out_sat, out_err, in_ready);
        end
        step();
        rst = 1'b0;
        send3(8'd1, 8'd2, 8'd3);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 20'd6) begin
            errors++;
            $display("FAIL post_reset_sum: got v=%0b d=%0d expected v=1 d=6", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_clear();
        in_valid = 1'b1; in_code = 8'd50; step();
        clear = 1'b1; in_valid = 1'b1; in_code = 8'd40;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready: got %0b expected 0", in_ready);
        end
        step();
        clear = 1'b0;
        send3(8'd2, 8'd3, 8'd4);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 20'd9) begin
            errors++;
            $display("FAIL clear_discard: got v=%0b d=%0d expected v=1 d=9", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_enable();
        in_valid = 1'b1; in_code = 8'd9; step();
        en = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL enable_low_ready: got %0b expected 0", in_ready);
        end
        step(); step();
        en = 1'b1;
        in_valid = 1'b1; in_code = 8'd9; step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_frozen_count: got v=%0b expected 0", out_valid);
        end
        in_valid = 1'b1; in_code = 8'd9; step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 20'd27) begin
            errors++;
            $display("FAIL enable_result: got v=%0b d=%0d expected v=1 d=27", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_saturation();
        send3(8'd221, 8'd221, 8'd221);
        checks++;
        if (out_valid14 !== 1'b1 || out_data14 !== 14'd16383 || out_sat14 !== 1'b1) begin
            errors++;
            $display("FAIL sat_w14: got v=%0b d=%0d s=%0b expected v=1 d=16383 s=1",
                     out_valid14, out_data14, out_sat14);
        end
        checks++;
        if (out_data !== 20'd24384 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL nosat_w20: got d=%0d s=%0b expected d=24384 s=0", out_data, out_sat);
        end
        step();
        send3(8'd1, 8'd2, 8'd3);
        checks++;
        if (out_data14 !== 14'd6 || out_sat14 !== 1'b0) begin
            errors++;
            $display("FAIL sat_cleared_w14: got d=%0d s=%0b expected d=6 s=0", out_data14, out_sat14);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_decode();
        test_illegal();
        test_backpressure();
        test_rst_mid();
        test_clear();
        test_enable();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/psum_decode_acc.md
PSUM_DECODE_ACC -- requirements
Module: psum_decode_acc

Interface
REQ-001 Parameter ACC_LEN, default 3: number of compressed psum codes summed per result; legal range 1..255.
REQ-002 Parameter ACC_W, default 20: accumulator and result width; legal range 14..32.
REQ-003 clk  input  1  single block clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  active-high enable; when low, the block is frozen.
REQ-006 clear  input  1  synchronous discard of the partial sum.
REQ-007 in_valid  input  1  in_code is valid.
REQ-008 in_code  input  8  compressed 8-bit psum code from the PE column.
REQ-009 in_ready  output  1  block accepts in_code this cycle.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  ACC_W  accumulated decoded sum.
REQ-013 out_sat  output  1  result saturated.
REQ-014 out_err  output  1  result contains at least one illegal code.

Function
REQ-015 Decode, combinational and 14-bit unsigned: code<64 -> code.
REQ-016 Decode: 64<=code<190 -> ((code-62)<<5)+16, giving the mid-bin value 80..4080.
REQ-017 Decode: 190<=code<222 -> ((code-158)<<7)+64, giving 4160..8128; the encoder's 8192..16383 bin aliases onto these codes and is decoded as this bin.
REQ-018 Decode: code>=222 is illegal -> 16383, and sets the result's error flag.
REQ-019 The FSM has two states, ACC and DONE; the reset state is ACC.
REQ-020 ACC: in_ready=1 whenever en=1; an accept (in_valid&&in_ready) adds the decoded value to acc and increments cnt.
REQ-021 An accept with cnt==ACC_LEN-1 loads out_data=acc+decode, latches the sat/err flags, clears acc and cnt, and moves to DONE; out_valid=1 the next cycle, so latency is one clock from the last accept.
REQ-022 DONE: out_valid=1, and out_data/out_sat/out_err are held stable until out_valid&&out_ready.
REQ-023 DONE with out_ready=1 and en=1: in_ready=1; on an accept in that same cycle the result is retired and the new code starts a fresh sum with acc=decode and cnt=1, with no bubble.
REQ-024 DONE with out_ready=1 and no accept: the block returns to ACC.
REQ-025 If ACC_LEN=1 and a DONE-cycle accept occurs, the block stays in DONE with the new result.
REQ-026 Accumulation is unsigned and saturates at 2^ACC_W-1; the saturation flag is sticky across the result's terms and is cleared when a new result starts.
REQ-027 en=0: in_ready=0, no state, acc, cnt or output changes, and out_valid holds its value.
REQ-028 clear=1 with en=1: acc, cnt and the partial flags go to 0; a pending DONE result is unaffected; an in_code presented that cycle is not accepted (in_ready=0).
REQ-029 out_valid never deasserts without a handshake except on rst.

Reset
REQ-030 rst asserted (asynchronously, at any time including mid-accumulation) forces state=ACC, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, out_err=0, and in_ready=0 while rst is high.
REQ-031 After rst deasserts, in_ready follows REQ-020 in the first clock; no pre-reset partial sum survives.

Verification
REQ-032 Defaults; codes 10,20,63 with out_ready=1 -> out_data=93, out_sat=0, out_err=0, out_valid for one cycle, one clock after the third accept.
REQ-033 Codes 64,189,190 -> decoded values 80, 4080, 4160; out_data=8320.
REQ-034 Codes 230,0,0 -> out_data=16383, out_err=1; the next result, codes 1,1,1 -> out_data=3, out_err=0.
REQ-035 Backpressure: out_ready=0 for 5 cycles -> out_data stable and in_ready=0; then out_ready=1 with in_valid=1 and code 5 -> accepted in the same cycle, and the next result includes 5.
REQ-036 rst pulse after 2 of 3 codes -> all outputs 0; the next result equals only the 3 post-reset codes.
REQ-037 ACC_W=14; codes 221,221,221 -> out_data=16383, out_sat=1.
